// File: rtl/stream_frame_arbiter.sv
// Frame-granular round-robin arbiter: two ready/valid pixel sources share
// one downstream stage, one full WIDTH x HEIGHT frame per grant.
module stream_frame_arbiter #(
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in0_valid,
  input  logic [DATA_WIDTH-1:0] in0_data,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  output logic                  in1_ready,
  output logic                  data_out_valid,
  output logic [DATA_WIDTH-1:0] data_out_data,
  input  logic                  data_out_ready,
  output logic                  data_out_src,
  output logic                  data_out_sof,
  output logic                  data_out_eol,
  output logic                  data_out_eof,
  output logic                  busy
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic active;
  logic sel_valid;
  logic xfer;
  logic at_eol;
  logic at_eof;
  logic winner;

  // Reset overrides the registered state so outputs drop the same cycle.
  assign active    = (state == BUSY) && !reset;
  assign sel_valid = owner ? in1_valid : in0_valid;

  assign data_out_valid = active && sel_valid;
  assign data_out_data  = owner ? in1_data : in0_data;
  assign data_out_src   = reset ? 1'b0 : owner;

  assign in0_ready = active && !owner && data_out_ready;
  assign in1_ready = active &&  owner && data_out_ready;

  assign at_eol = (x == XMAX);
  assign at_eof = at_eol && (y == YMAX);

  assign data_out_sof = active && (x == '0) && (y == '0);
  assign data_out_eol = active && at_eol;
  assign data_out_eof = active && at_eof;

  assign busy = active;
  assign xfer = data_out_valid && data_out_ready;

  // Contested grant goes to whichever source did not own the last frame.
  assign winner = (in0_valid && in1_valid) ? ~last_grant : in1_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      x          <= '0;
      y          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in0_valid || in1_valid) begin
            owner <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            if (at_eof) begin
              x          <= '0;
              y          <= '0;
              last_grant <= owner;
              state      <= IDLE;
            end else if (at_eol) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_frame_arbiter.sv
// Bench for stream_frame_arbiter: 2x2 vector table plus a 32x32
// scoreboard run covering contention, backpressure, stalls and reset.
module tb_stream_frame_arbiter;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int DW = 16;
  localparam int FR = W * H;

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
    logic          eof;
  } beat_t;

  // ex bits: valid, src, sof, eol, eof, busy, in0_ready, in1_ready
  typedef struct packed {
    logic       rst;
    logic       v0;
    logic       v1;
    logic       rdy;
    logic [7:0] ex;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in0_valid, in1_valid, in0_ready, in1_ready;
  logic [DW-1:0] in0_data, in1_data, data_out_data;
  logic          data_out_valid, data_out_ready, data_out_src;
  logic          data_out_sof, data_out_eol, data_out_eof, busy;

  logic          s_reset;
  logic          s_in0_valid, s_in1_valid, s_in0_ready, s_in1_ready;
  logic [DW-1:0] s_in0_data, s_in1_data, s_data;
  logic          s_valid, s_ready, s_src, s_sof, s_eol, s_eof, s_busy;

  stream_frame_arbiter #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .data_out_valid(data_out_valid), .data_out_data(data_out_data),
    .data_out_ready(data_out_ready), .data_out_src(data_out_src),
    .data_out_sof(data_out_sof), .data_out_eol(data_out_eol),
    .data_out_eof(data_out_eof), .busy(busy)
  );

  stream_frame_arbiter #(.WIDTH(2), .HEIGHT(2), .DATA_WIDTH(DW)) dut_small (
    .clk(clk), .reset(s_reset),
    .in0_valid(s_in0_valid), .in0_data(s_in0_data), .in0_ready(s_in0_ready),
    .in1_valid(s_in1_valid), .in1_data(s_in1_data), .in1_ready(s_in1_ready),
    .data_out_valid(s_valid), .data_out_data(s_data),
    .data_out_ready(s_ready), .data_out_src(s_src),
    .data_out_sof(s_sof), .data_out_eol(s_eol),
    .data_out_eof(s_eof), .busy(s_busy)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  int    cnt0 = 0, cnt1 = 0, exp0 = 0, exp1 = 0;
  int    cyc = 0, rel_cyc = 0, last_eof_cyc = 0, beats = 0, r1_hits = 0;
  bit    gap_chk = 0, have_eof = 0, first_chk = 0, rdy_rand = 0;
  bit    en0 = 0, en1 = 0, acc0 = 0, acc1 = 0, cur_src = 0;
  vec_t  tbl [24];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input bit s);
    beat_t b;
    for (int i = 0; i < FR; i++) begin
      b.src  = s;
      b.data = s ? (16'h8000 | exp1[15:0]) : exp0[15:0];
      b.sof  = (i == 0);
      b.eol  = ((i % W) == W - 1);
      b.eof  = (i == FR - 1);
      sb.push_back(b);
      if (s) exp1++;
      else exp0++;
    end
  endtask

  task automatic monitor();
    beat_t a, e;
    cyc++;
    acc0 = in0_valid && in0_ready;
    acc1 = in1_valid && in1_ready;
    if (in1_ready) r1_hits++;
    if (reset)
      chk("reset_out", 64'({data_out_valid, busy, in0_ready, in1_ready,
          data_out_sof, data_out_eol, data_out_eof, data_out_src}), 64'(0));
    else if (!busy)
      chk("idle_out", 64'({data_out_valid, in0_ready, in1_ready,
          data_out_sof, data_out_eol, data_out_eof}), 64'(0));
    else
      chk("ready_route",
          64'({data_out_src ? in0_ready : in1_ready,
               data_out_src ? in1_ready : in0_ready}),
          64'({1'b0, data_out_ready}));
    if (data_out_valid && data_out_ready) begin
      a.src  = data_out_src;
      a.data = data_out_data;
      a.sof  = data_out_sof;
      a.eol  = data_out_eol;
      a.eof  = data_out_eof;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got %0h, required no beat", a);
      end else begin
        e = sb.pop_front();
        chk("beat", 64'(a), 64'(e));
      end
      if (data_out_sof) begin
        beats = 0;
        if (first_chk) begin
          chk("first_latency", 64'(cyc - rel_cyc), 64'(1));
          first_chk = 0;
        end else if (gap_chk && have_eof) begin
          chk("frame_gap", 64'(cyc - last_eof_cyc), 64'(2));
        end
      end
      beats++;
      cur_src = data_out_src;
      if (data_out_eof) begin
        last_eof_cyc = cyc;
        have_eof = 1;
      end
    end
  endtask

  task automatic drive();
    in0_valid = en0;
    in0_data  = cnt0[15:0];
    in1_valid = en1;
    in1_data  = 16'h8000 | cnt1[15:0];
    data_out_ready = rdy_rand ? 1'($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (acc0) cnt0++;
    if (acc1) cnt1++;
    drive();
  endtask

  task automatic do_reset(input bit first);
    reset = 1'b1;
    drive();
    tick();
    reset = 1'b0;
    drive();
    rel_cyc   = cyc + 1;
    first_chk = first;
    have_eof  = 0;
    beats     = 0;
  endtask

  task automatic run_empty(input int budget, input string name);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats left, required 0", name, sb.size());
    end
  endtask

  task automatic wait_beat(input bit s, input int nb, input string name);
    int n = 0;
    while (!(cur_src == s && beats >= nb) && n < 4000) begin
      tick();
      n++;
    end
    chk(name, 64'(beats), 64'(nb));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    logic [7:0] act;
    reset = 1'b1;
    en0 = 0;
    en1 = 0;
    drive();
    s_in0_data = 16'h1111;
    s_in1_data = 16'h2222;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'b0000_0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'b1110_0101};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'b1101_0100};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'b1101_0101};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b0100_0101};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1100_0101};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1101_1101};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b0100_0000};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1010_0110};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1001_0110};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1000_0110};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1001_1110};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0000};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1110_0101};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1101_0101};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1100_0101};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1101_1101};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b0100_0000};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1010_0110};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0000};
    tbl[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'b0000_0000};
    tbl[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1110_0101};

    for (int i = 0; i < 24; i++) begin
      s_reset     = tbl[i].rst;
      s_in0_valid = tbl[i].v0;
      s_in1_valid = tbl[i].v1;
      s_ready     = tbl[i].rdy;
      @(negedge clk);
      act = {s_valid, s_src, s_sof, s_eol, s_eof, s_busy,
             s_in0_ready, s_in1_ready};
      chk($sformatf("small_row%0d", i),
          64'({act, s_valid ? s_data : 16'h0}),
          64'({tbl[i].ex, tbl[i].ex[7] ?
               (tbl[i].ex[6] ? 16'h2222 : 16'h1111) : 16'h0}));
      @(posedge clk);
      #1;
    end
    s_reset = 1'b1;

    // single source, two frames back to back
    en0 = 1;
    en1 = 0;
    gap_chk = 1;
    push_frame(0);
    push_frame(0);
    do_reset(1);
    r1_hits = 0;
    run_empty(3000, "single");
    chk("single_in1_ready", 64'(r1_hits), 64'(0));

    // contention: expect 0,1,0,1
    en1 = 1;
    push_frame(0);
    push_frame(1);
    push_frame(0);
    push_frame(1);
    do_reset(1);
    run_empty(6000, "contention");

    // random backpressure on the output
    en1 = 0;
    rdy_rand = 1;
    gap_chk = 0;
    push_frame(0);
    push_frame(0);
    do_reset(0);
    run_empty(12000, "backpressure");
    rdy_rand = 0;

    // owner 0 stalls for 50 cycles while source 1 waits
    en1 = 1;
    gap_chk = 1;
    push_frame(0);
    push_frame(1);
    do_reset(1);
    wait_beat(0, 300, "stall_reach");
    en0 = 0;
    drive();
    r1_hits = 0;
    repeat (50) tick();
    chk("stall_in1_ready", 64'(r1_hits), 64'(0));
    en0 = 1;
    drive();
    run_empty(3000, "stall");

    // reset in the middle of a source-1 frame
    push_frame(0);
    push_frame(1);
    do_reset(1);
    wait_beat(1, 500, "midreset_reach");
    while (sb.size() > 0) begin
      b = sb.pop_back();
      if (b.src) exp1--;
      else exp0--;
    end
    push_frame(0);
    push_frame(1);
    do_reset(1);
    run_empty(3000, "post_reset");
    chk("src1_resume", 64'(cnt1), 64'(exp1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
